serial_adder: RTL

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 90 +++++++++
 1 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: operands are captured on start and added one bit per clock, LSB first.
// The registered sum/carry_out update once per operation, together with a one-cycle done pulse.
module serial_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             busy,
    output logic             done
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, next_state;
    logic [WIDTH-1:0] a_sh, b_sh, res_sh;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             bit_s, carry_nxt, last_bit;
    logic [WIDTH-1:0] res_nxt;

    // One full-adder slice on the current LSBs
    assign bit_s     = a_sh[0] ^ b_sh[0] ^ carry;
    assign carry_nxt = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
    assign res_nxt   = {bit_s, res_sh[WIDTH-1:1]};
    assign last_bit  = (cnt == CW'(WIDTH - 1));

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = ADD;
            ADD:     if (last_bit) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state     <= IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            res_sh    <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            sum       <= '0;
            carry_out <= 1'b0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        res_sh <= '0;
                        carry  <= carry_in;
                        cnt    <= '0;
                    end
                end
                ADD: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= res_nxt;
                    carry  <= carry_nxt;
                    cnt    <= cnt + CW'(1);
                    // Outputs change only when the final bit lands
                    if (last_bit) begin
                        sum       <= res_nxt;
                        carry_out <= carry_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == ADD);
    assign done = (state == DONE);

endmodule
